// File: rtl/prio_enc_pkg.sv
// Shared definitions for the parametrised priority encoder.
//   MODE_FIXED / MODE_RR : values of in_mode_rr
//   rr_next(code, n)     : round-robin pointer that follows a win at 'code'
//                          among 'n' request lines, wrapping N-1 -> 0 explicitly
package prio_enc_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Explicit wrap so non-power-of-two N never lands on an index >= N.
    function automatic int rr_next(input int code, input int n);
        return (code == n - 1) ? 0 : code + 1;
    endfunction

endpackage

// File: rtl/prio_find.sv
// Combinational winner search over an N-bit request vector.
//   vec      in  N  request vector
//   start    in  W  first index examined in ascending mode (must be < N)
//   dir_high in  1  1 = highest set index wins; 0 = ascending from start, wrapping
//   code     out W  winning index (0 when none)
//   onehot   out N  one-hot of the winner (0 when none)
//   none     out 1  vec is all zero
module prio_find #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] start,
    input  logic         dir_high,
    output logic [W-1:0] code,
    output logic [N-1:0] onehot,
    output logic         none
);

    always_comb begin
        int s;
        int idx;
        code = '0;
        none = ~|vec;
        s    = int'(start);
        idx  = 0;
        if (dir_high) begin
            // Ascending scan: the last hit is the highest set index.
            for (int i = 0; i < N; i++) begin
                if (vec[i]) code = W'(i);
            end
        end else begin
            // Scan offsets from far to near so the nearest hit at or after
            // start (modulo N) is the one left in code.
            for (int k = N - 1; k >= 0; k--) begin
                idx = s + k;
                if (idx >= N) idx = idx - N;
                if (vec[idx]) code = W'(idx);
            end
        end
        onehot = none ? '0 : (N'(1) << code);
    end

endmodule

// File: rtl/prio_encoder_rr.sv
// N-to-log2(N) priority encoder with registered result and valid/ready on
// both sides. Each accepted beat is reduced to one winning index, either by
// fixed priority (highest index wins) or round-robin from an internal pointer.
//   clk, rst    clock, synchronous active-high reset
//   in_valid    in   beat present on in_data / in_mode_rr
//   in_ready    out  beat can be taken this cycle
//   in_data     in   N-bit request vector
//   in_mode_rr  in   0 = fixed priority, 1 = round-robin
//   out_valid   out  result held in the output register
//   out_ready   in   consumer takes the result this cycle
//   out_code    out  W-bit winning index
//   out_onehot  out  one-hot of the winner (zero when out_zero)
//   out_zero    out  accepted request vector was all zero
module prio_encoder_rr #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic         in_mode_rr,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_code,
    output logic [N-1:0] out_onehot,
    output logic         out_zero
);
    import prio_enc_pkg::*;

    logic [W-1:0] f_code;
    logic [N-1:0] f_onehot;
    logic         f_none;
    logic         accept;

    logic [W-1:0] ptr;
    logic         vld_p1;
    logic [W-1:0] code_p1;
    logic [N-1:0] onehot_p1;
    logic         zero_p1;

    // Single output slot: free when empty or being drained this cycle.
    assign in_ready = !vld_p1 || out_ready;
    assign accept   = in_valid && in_ready;

    prio_find #(.N(N), .W(W)) u_find (
        .vec      (in_data),
        .start    (ptr),
        .dir_high (in_mode_rr == MODE_FIXED),
        .code     (f_code),
        .onehot   (f_onehot),
        .none     (f_none)
    );

    // ---- stage p1: output register and round-robin pointer ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            code_p1   <= '0;
            onehot_p1 <= '0;
            zero_p1   <= 1'b0;
            ptr       <= '0;
        end else if (accept) begin
            vld_p1    <= 1'b1;
            code_p1   <= f_code;
            onehot_p1 <= f_onehot;
            zero_p1   <= f_none;
            if (in_mode_rr == MODE_RR && !f_none)
                ptr <= W'(rr_next(int'(f_code), N));
        end else if (out_ready) begin
            // Drained with nothing new: result fields keep their last values.
            vld_p1 <= 1'b0;
        end
    end

    assign out_valid  = vld_p1;
    assign out_code   = code_p1;
    assign out_onehot = onehot_p1;
    assign out_zero   = zero_p1;

endmodule

// File: tb/tb_prio_encoder_rr.sv
module tb_prio_encoder_rr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // N = 8 instance
    logic       rst8, in_valid8, in_ready8, mode8, out_valid8, out_ready8, out_zero8;
    logic [7:0] in_data8, out_onehot8;
    logic [2:0] out_code8;

    prio_encoder_rr #(.N(8)) dut8 (
        .clk(clk), .rst(rst8), .in_valid(in_valid8), .in_ready(in_ready8),
        .in_data(in_data8), .in_mode_rr(mode8), .out_valid(out_valid8),
        .out_ready(out_ready8), .out_code(out_code8), .out_onehot(out_onehot8),
        .out_zero(out_zero8)
    );

    // N = 5 instance
    logic       rst5, in_valid5, in_ready5, mode5, out_valid5, out_ready5, out_zero5;
    logic [4:0] in_data5, out_onehot5;
    logic [2:0] out_code5;

    prio_encoder_rr #(.N(5)) dut5 (
        .clk(clk), .rst(rst5), .in_valid(in_valid5), .in_ready(in_ready5),
        .in_data(in_data5), .in_mode_rr(mode5), .out_valid(out_valid5),
        .out_ready(out_ready5), .out_code(out_code5), .out_onehot(out_onehot5),
        .out_zero(out_zero5)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset8();
        rst8 = 1'b1; in_valid8 = 1'b0; in_data8 = '0; mode8 = 1'b0; out_ready8 = 1'b1;
        tick(); tick();
        rst8 = 1'b0;
    endtask

    task automatic test_reset();
        reset8();
        rst8 = 1'b1;
        tick(); tick();
        total++; if (out_valid8 !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0d want=0", out_valid8); end
        total++; if (out_code8 !== 3'd0) begin bad++; $display("FAIL reset_out_code got=%0d want=0", out_code8); end
        total++; if (out_onehot8 !== 8'h00) begin bad++; $display("FAIL reset_out_onehot got=%h want=00", out_onehot8); end
        total++; if (out_zero8 !== 1'b0) begin bad++; $display("FAIL reset_out_zero got=%0d want=0", out_zero8); end
        total++; if (in_ready8 !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0d want=1", in_ready8); end
        rst8 = 1'b0;
    endtask

    task automatic test_fixed();
        in_valid8 = 1'b1; in_data8 = 8'b0010_1010; mode8 = 1'b0; out_ready8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        total++; if (out_valid8 !== 1'b1) begin bad++; $display("FAIL fixed_valid got=%0d want=1", out_valid8); end
        total++; if (out_code8 !== 3'd5) begin bad++; $display("FAIL fixed_code got=%0d want=5", out_code8); end
        total++; if (out_onehot8 !== 8'h20) begin bad++; $display("FAIL fixed_onehot got=%h want=20", out_onehot8); end
        total++; if (out_zero8 !== 1'b0) begin bad++; $display("FAIL fixed_zero got=%0d want=0", out_zero8); end
        tick();
        total++; if (out_valid8 !== 1'b0) begin bad++; $display("FAIL drain_valid got=%0d want=0", out_valid8); end
        total++; if (out_code8 !== 3'd5) begin bad++; $display("FAIL drain_code_kept got=%0d want=5", out_code8); end
        total++; if (out_onehot8 !== 8'h20) begin bad++; $display("FAIL drain_onehot_kept got=%h want=20", out_onehot8); end
    endtask

    task automatic test_zero();
        in_valid8 = 1'b1; in_data8 = 8'h00; mode8 = 1'b1; out_ready8 = 1'b1;
        tick();
        total++; if (out_zero8 !== 1'b1) begin bad++; $display("FAIL zero_flag got=%0d want=1", out_zero8); end
        total++; if (out_code8 !== 3'd0) begin bad++; $display("FAIL zero_code got=%0d want=0", out_code8); end
        total++; if (out_onehot8 !== 8'h00) begin bad++; $display("FAIL zero_onehot got=%h want=00", out_onehot8); end
        in_data8 = 8'hFF;
        tick();
        in_valid8 = 1'b0;
        total++; if (out_code8 !== 3'd0) begin bad++; $display("FAIL zero_then_rr_code got=%0d want=0", out_code8); end
        total++; if (out_onehot8 !== 8'h01) begin bad++; $display("FAIL zero_then_rr_onehot got=%h want=01", out_onehot8); end
        total++; if (out_zero8 !== 1'b0) begin bad++; $display("FAIL zero_then_rr_flag got=%0d want=0", out_zero8); end
        tick();
    endtask

    task automatic test_backpressure();
        in_valid8 = 1'b1; in_data8 = 8'h01; mode8 = 1'b0; out_ready8 = 1'b1;
        tick();
        out_ready8 = 1'b0; in_data8 = 8'h80;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (in_ready8 !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d] got=%0d want=0", i, in_ready8); end
            tick();
            total++; if (out_valid8 !== 1'b1 || out_code8 !== 3'd0 || out_onehot8 !== 8'h01) begin
                bad++; $display("FAIL bp_hold[%0d] got=v%0d c%0d o%h want=v1 c0 o01", i, out_valid8, out_code8, out_onehot8);
            end
        end
        out_ready8 = 1'b1;
        #1;
        total++; if (in_ready8 !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%0d want=1", in_ready8); end
        tick();
        in_valid8 = 1'b0;
        total++; if (out_valid8 !== 1'b1 || out_code8 !== 3'd7 || out_onehot8 !== 8'h80) begin
            bad++; $display("FAIL bp_b_result got=v%0d c%0d o%h want=v1 c7 o80", out_valid8, out_code8, out_onehot8);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        reset8();
        in_valid8 = 1'b1; in_data8 = 8'hFF; mode8 = 1'b1; out_ready8 = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            total++; if (out_valid8 !== 1'b1 || out_code8 !== 3'(i % 8) || in_ready8 !== 1'b1) begin
                bad++; $display("FAIL b2b[%0d] got=v%0d c%0d r%0d want=v1 c%0d r1", i, out_valid8, out_code8, in_ready8, i % 8);
            end
        end
        // ptr is now 1; a fixed beat must not move it
        mode8 = 1'b0;
        tick();
        total++; if (out_code8 !== 3'd7) begin bad++; $display("FAIL mix_fixed_code got=%0d want=7", out_code8); end
        mode8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        total++; if (out_code8 !== 3'd1) begin bad++; $display("FAIL mix_rr_code got=%0d want=1", out_code8); end
        tick();
    endtask

    task automatic test_rr_wrap5();
        int exp5 [8] = '{0, 1, 2, 3, 4, 0, 1, 2};
        rst5 = 1'b1; in_valid5 = 1'b0; in_data5 = '0; mode5 = 1'b1; out_ready5 = 1'b1;
        tick(); tick();
        rst5 = 1'b0;
        in_valid5 = 1'b1; in_data5 = 5'b11111;
        for (int i = 0; i < 8; i++) begin
            tick();
            total++; if (out_valid5 !== 1'b1 || out_code5 !== 3'(exp5[i])) begin
                bad++; $display("FAIL wrap5[%0d] got=v%0d c%0d want=v1 c%0d", i, out_valid5, out_code5, exp5[i]);
            end
            if (i == 4) begin
                total++; if (out_onehot5 !== 5'b10000) begin bad++; $display("FAIL wrap5_onehot4 got=%b want=10000", out_onehot5); end
            end
        end
        in_data5 = 5'b00101;
        tick();
        total++; if (out_code5 !== 3'd0) begin bad++; $display("FAIL wrap5_sparse0 got=%0d want=0", out_code5); end
        tick();
        total++; if (out_code5 !== 3'd2 || out_onehot5 !== 5'b00100) begin
            bad++; $display("FAIL wrap5_sparse1 got=c%0d o%b want=c2 o00100", out_code5, out_onehot5);
        end
        // reset while a beat is offered: reset wins
        rst5 = 1'b1; in_data5 = 5'b11111;
        tick();
        total++; if (out_valid5 !== 1'b0) begin bad++; $display("FAIL wrap5_rst_valid got=%0d want=0", out_valid5); end
        rst5 = 1'b0;
        tick();
        in_valid5 = 1'b0;
        total++; if (out_valid5 !== 1'b1 || out_code5 !== 3'd0) begin
            bad++; $display("FAIL wrap5_after_rst got=v%0d c%0d want=v1 c0", out_valid5, out_code5);
        end
        tick();
    endtask

    initial begin
        rst5 = 1'b1; in_valid5 = 1'b0; in_data5 = '0; mode5 = 1'b0; out_ready5 = 1'b1;
        test_reset();
        test_fixed();
        test_zero();
        test_backpressure();
        test_back_to_back();
        test_rr_wrap5();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
